memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 41 ++++
 rtl/memory_arbiter.sv | 173 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | memory_arbiter_if : requester and memory_system bundle  (rev 1.0)|
// +------------------------------------------------------------------+
interface memory_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [2*NUM_REQ-1:0]  req_width;
  logic [NUM_REQ-1:0]    done;
  logic [31:0]           rdata;
  logic                  err;
  logic [1:0]            grant_id;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_write_data;
  logic [1:0]            mem_mem_width;
  logic                  mem_dispatch_read;
  logic                  mem_dispatch_write;
  logic [31:0]           mem_read_data;
  logic                  mem_busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_width,
    input  mem_read_data, mem_busy,
    output done, rdata, err, grant_id,
    output mem_addr, mem_write_data, mem_mem_width,
    output mem_dispatch_read, mem_dispatch_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_width,
    output mem_read_data, mem_busy,
    input  done, rdata, err, grant_id,
    input  mem_addr, mem_write_data, mem_mem_width,
    input  mem_dispatch_read, mem_dispatch_write
  );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | memory_arbiter : round-robin single-outstanding memory arbiter   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module memory_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic       clk_in,
  input  wire logic       rst_in,
  memory_arbiter_if.slave bus
);
  localparam int               CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_tmo_last   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       c_last_reset = 2'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic               write_q, write_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         width_q, width_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic               disp_rd_q, disp_rd_d;
  logic               disp_wr_q, disp_wr_d;

  logic [3:0]  valid_ext;
  logic [1:0]  cand;
  logic        win_found;
  logic [1:0]  win_id;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_width;

  // Search starts just after the last served requester so it ends up last.
  always_comb begin
    valid_ext = 4'(bus.req_valid);
    cand      = 2'd0;
    win_found = 1'b0;
    win_id    = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && valid_ext[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_width = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win_id == 2'(j)) begin
        sel_write = bus.req_write[j];
        sel_addr  = bus.req_addr[32*j +: 32];
        sel_wdata = bus.req_wdata[32*j +: 32];
        sel_width = bus.req_width[2*j +: 2];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    width_d      = width_q;
    rdata_d      = rdata_q;
    tmo_cnt_d    = tmo_cnt_q;
    done_d       = '0;
    err_d        = 1'b0;
    disp_rd_d    = 1'b0;
    disp_wr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // done_q blocks the cycle where the served requester may still show valid.
        if (win_found && !bus.mem_busy && (done_q == '0)) begin
          grant_id_d = win_id;
          write_d    = sel_write;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          width_d    = (sel_width == 2'd3) ? 2'd2 : sel_width;
          disp_rd_d  = !sel_write;
          disp_wr_d  = sel_write;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.mem_busy) begin
          if (!write_q) begin
            rdata_d = bus.mem_read_data;
          end
          done_d       = NUM_REQ'(1) << grant_id_q;
          last_grant_d = grant_id_q;
          state_d      = ST_IDLE;
        end else if (tmo_cnt_q == c_tmo_last) begin
          rdata_d      = '0;
          err_d        = 1'b1;
          done_d       = NUM_REQ'(1) << grant_id_q;
          last_grant_d = grant_id_q;
          state_d      = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      last_grant_q <= c_last_reset;
      grant_id_q   <= 2'd0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      width_q      <= '0;
      rdata_q      <= '0;
      tmo_cnt_q    <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      disp_rd_q    <= 1'b0;
      disp_wr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      width_q      <= width_d;
      rdata_q      <= rdata_d;
      tmo_cnt_q    <= tmo_cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      disp_rd_q    <= disp_rd_d;
      disp_wr_q    <= disp_wr_d;
    end
  end

  assign bus.done               = done_q;
  assign bus.err                = err_q;
  assign bus.rdata              = rdata_q;
  assign bus.grant_id           = grant_id_q;
  assign bus.mem_addr           = addr_q;
  assign bus.mem_write_data     = wdata_q;
  assign bus.mem_mem_width      = width_q;
  assign bus.mem_dispatch_read  = disp_rd_q;
  assign bus.mem_dispatch_write = disp_wr_q;
endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_memory_arbiter : directed + random bench with reference model |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_memory_arbiter;
  localparam int NUM_REQ = 3;
  localparam int TMO     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  memory_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  memory_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  // requester stimulus
  logic [NUM_REQ-1:0] r_v = '0;
  logic [NUM_REQ-1:0] r_w = '0;
  logic [31:0]        r_a  [NUM_REQ];
  logic [31:0]        r_d  [NUM_REQ];
  logic [1:0]         r_wd [NUM_REQ];

  assign bus.req_valid = r_v;
  assign bus.req_write = r_w;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign bus.req_addr[32*g +: 32]  = r_a[g];
    assign bus.req_wdata[32*g +: 32] = r_d[g];
    assign bus.req_width[2*g +: 2]   = r_wd[g];
  end

  // memory_system stand-in: busy in the dispatch cycle plus B more cycles
  int          mem_b      = 0;
  int          mem_bmax   = 4;
  bit          rand_rdata = 1'b0;
  logic [31:0] next_rdata = 32'h0;
  int          rem        = 0;

  assign bus.mem_busy = (rem > 0);

  initial begin
    bus.mem_read_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_dispatch_read || bus.mem_dispatch_write) begin
        rem = 1 + ((mem_b < 0) ? int'($urandom_range(0, mem_bmax)) : mem_b);
        bus.mem_read_data = rand_rdata ? $urandom : next_rdata;
      end else if (rem > 0) begin
        rem = rem - 1;
      end
    end
  end

  // Reference model: transaction-level view of the arbiter.
  bit                 m_ok     = 1'b0;
  bit                 m_active = 1'b0;
  bit                 m_cool   = 1'b0;
  bit                 m_write  = 1'b0;
  int                 m_age    = 0;
  int                 m_id     = 0;
  int                 m_last   = NUM_REQ - 1;
  logic [NUM_REQ-1:0] e_done   = '0;
  logic               e_err    = 1'b0;
  logic               e_rd     = 1'b0;
  logic               e_wr     = 1'b0;
  logic [31:0]        e_rdata  = '0;
  logic [31:0]        e_addr   = '0;
  logic [31:0]        e_wdata  = '0;
  logic [1:0]         e_width  = '0;
  logic [1:0]         e_grant  = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ok = 1'b1; m_active = 1'b0; m_cool = 1'b0; m_last = NUM_REQ - 1;
      e_done = '0; e_err = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_rdata = '0;
      e_addr = '0; e_wdata = '0; e_width = '0; e_grant = '0;
    end else if (m_ok) begin
      e_done = '0; e_err = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      if (!m_active) begin
        if (m_cool) begin
          m_cool = 1'b0;
        end else if ((bus.req_valid != '0) && !bus.mem_busy) begin
          for (int k = 1; k <= NUM_REQ; k++) begin
            if (bus.req_valid[2'((m_last + k) % NUM_REQ)]) begin
              m_id = (m_last + k) % NUM_REQ;
              break;
            end
          end
          m_write  = r_w[m_id];
          e_grant  = 2'(m_id);
          e_addr   = r_a[m_id];
          e_wdata  = r_d[m_id];
          e_width  = (r_wd[m_id] == 2'd3) ? 2'd2 : r_wd[m_id];
          e_rd     = !m_write;
          e_wr     = m_write;
          m_active = 1'b1;
          m_age    = 0;
        end
      end else begin
        m_age = m_age + 1;
        if (m_age >= 2) begin
          if (!bus.mem_busy) begin
            e_done = NUM_REQ'(1) << m_id;
            if (!m_write) e_rdata = bus.mem_read_data;
          end else if (m_age - 1 == TMO) begin
            e_done  = NUM_REQ'(1) << m_id;
            e_err   = 1'b1;
            e_rdata = '0;
          end
          if (e_done != '0) begin
            m_last = m_id; m_active = 1'b0; m_cool = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("done",       32'(bus.done),               32'(e_done));
      chk("err",        32'(bus.err),                32'(e_err));
      chk("rdata",      bus.rdata,                   e_rdata);
      chk("grant_id",   32'(bus.grant_id),           32'(e_grant));
      chk("mem_addr",   bus.mem_addr,                e_addr);
      chk("mem_wdata",  bus.mem_write_data,          e_wdata);
      chk("mem_width",  32'(bus.mem_mem_width),      32'(e_width));
      chk("disp_read",  32'(bus.mem_dispatch_read),  32'(e_rd));
      chk("disp_write", 32'(bus.mem_dispatch_write), 32'(e_wr));
    end
  end

  // dispatch monitor
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] disp_wdata = '0;
  logic [1:0]  disp_width = '0;
  always @(negedge clk) begin
    if (bus.mem_dispatch_read)  n_rd++;
    if (bus.mem_dispatch_write) n_wr++;
    if (bus.mem_dispatch_read || bus.mem_dispatch_write) begin
      disp_wdata = bus.mem_write_data;
      disp_width = bus.mem_mem_width;
    end
  end

  task automatic set_req(input int i, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] wd);
    r_v[i] = 1'b1; r_w[i] = wr; r_a[i] = a; r_d[i] = d; r_wd[i] = wd;
  endtask

  task automatic wait_done(output int lat, output logic [NUM_REQ-1:0] dv);
    lat = -1;
    dv  = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        lat = n - 1;
        dv  = bus.done;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_done: no done within 100 cycles at %0t", $time);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int                 lat;
    int                 base;
    int                 cnt0;
    int                 cnt1;
    int                 n_done;
    logic [NUM_REQ-1:0] dv;

    for (int i = 0; i < NUM_REQ; i++) begin
      r_a[i] = '0; r_d[i] = '0; r_wd[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_done",  32'(bus.done),     32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_addr",  bus.mem_addr,      32'd0);
    chk("rst_rdata", bus.rdata,         32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single read, busy 1 cycle
    mem_b = 1; next_rdata = 32'h5A; base = n_rd + n_wr;
    set_req(0, 1'b0, 32'h3000_0000, 32'h0, 2'd0);
    wait_done(lat, dv);
    r_v[0] = 1'b0;
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_done",    32'(dv),  32'd1);
    chk("t1_rdata",   bus.rdata, 32'h5A);
    chk("t1_err",     32'(bus.err), 32'd0);
    chk("t1_nrd",     32'(n_rd + n_wr - base), 32'd1);
    repeat (3) @(negedge clk);

    // write, busy 0 cycles
    mem_b = 0; base = n_wr;
    set_req(1, 1'b1, 32'h2000_0010, 32'hF800, 2'd1);
    wait_done(lat, dv);
    r_v[1] = 1'b0;
    chk("t2_latency", 32'(lat), 32'd2);
    chk("t2_done",    32'(dv),  32'd2);
    chk("t2_rdata",   bus.rdata, 32'h5A);
    chk("t2_wdata",   disp_wdata, 32'h0000_F800);
    chk("t2_nwr",     32'(n_wr - base), 32'd1);
    repeat (3) @(negedge clk);

    // width code 3 dispatches as DWORD
    set_req(0, 1'b0, 32'h0000_0100, 32'h0, 2'd3);
    wait_done(lat, dv);
    r_v[0] = 1'b0;
    chk("t3_width", 32'(disp_width), 32'd2);
    repeat (3) @(negedge clk);

    // two requesters held continuously: strict alternation starting at 1
    mem_b = -1; mem_bmax = 4; cnt0 = 0; cnt1 = 0;
    set_req(0, 1'b0, 32'h0000_1000, 32'h0, 2'd2);
    set_req(1, 1'b1, 32'h0000_2000, 32'h1111, 2'd2);
    for (int k = 0; k < 8; k++) begin
      wait_done(lat, dv);
      chk("t4_order", 32'(dv), (k % 2 == 0) ? 32'd2 : 32'd1);
      if (dv[0]) begin
        cnt0++;
        if (cnt0 < 4) set_req(0, 1'b0, 32'h0000_1000 + 32'(cnt0 * 4), 32'h0, 2'd2);
        else r_v[0] = 1'b0;
      end
      if (dv[1]) begin
        cnt1++;
        if (cnt1 < 4) set_req(1, 1'b1, 32'h0000_2000 + 32'(cnt1 * 4), 32'(cnt1), 2'd2);
        else r_v[1] = 1'b0;
      end
    end
    chk("t4_cnt0", 32'(cnt0), 32'd4);
    chk("t4_cnt1", 32'(cnt1), 32'd4);
    repeat (3) @(negedge clk);

    // timeout with a second requester pending
    mem_b = 20;
    set_req(0, 1'b0, 32'h3000_0040, 32'h0, 2'd1);
    set_req(1, 1'b0, 32'h3000_0080, 32'h0, 2'd0);
    wait_done(lat, dv);
    r_v[1] = 1'b0;
    mem_b = 0;
    chk("t5_latency", 32'(lat), 32'(TMO + 1));
    chk("t5_done",    32'(dv),  32'd2);
    chk("t5_err",     32'(bus.err), 32'd1);
    chk("t5_rdata",   bus.rdata, 32'd0);
    base = n_rd + n_wr;
    for (int n = 0; n < 100 && bus.mem_busy; n++) @(negedge clk);
    chk("t5_hold_off", 32'(n_rd + n_wr - base), 32'd0);
    wait_done(lat, dv);
    r_v[0] = 1'b0;
    chk("t5_req0",     32'(dv),  32'd1);
    chk("t5_req0_lat", 32'(lat), 32'd2);
    repeat (3) @(negedge clk);

    // reset in the middle of WAIT
    mem_b = 30;
    set_req(1, 1'b1, 32'h2000_0100, 32'hABCD, 2'd1);
    for (int n = 0; n < 20 && !bus.mem_dispatch_write; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    set_req(0, 1'b0, 32'h3000_0000, 32'h0, 2'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_b = 1; next_rdata = 32'h77;
    chk("t6_done",  32'(bus.done),     32'd0);
    chk("t6_grant", 32'(bus.grant_id), 32'd0);
    chk("t6_addr",  bus.mem_addr,      32'd0);
    chk("t6_disp",  32'({bus.mem_dispatch_read, bus.mem_dispatch_write}), 32'd0);
    wait_done(lat, dv);
    r_v[0] = 1'b0;
    chk("t6_first",       32'(dv), 32'd1);
    chk("t6_first_rdata", bus.rdata, 32'h77);
    wait_done(lat, dv);
    r_v[1] = 1'b0;
    chk("t6_second", 32'(dv), 32'd2);
    repeat (3) @(negedge clk);

    // randomized traffic, including timeouts, withdrawals and one reset
    mem_b = -1; mem_bmax = 10; rand_rdata = 1'b1; n_done = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = !(c == 2000);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_v[i] && bus.done[i]) begin
          r_v[i] = 1'b0;
          n_done++;
        end else if (!r_v[i] && ($urandom_range(0, 3) == 0)) begin
          set_req(i, 1'($urandom), $urandom, $urandom, 2'($urandom));
        end else if (r_v[i] && !(m_active && m_id == i) && ($urandom_range(0, 31) == 0)) begin
          r_v[i] = 1'b0;
        end
      end
    end
    rst_n = 1'b1;
    chk("rand_progress", 32'(n_done > 50), 32'd1);
    r_v = '0;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
